// File: rtl/neander_pkg.sv
// neander_pkg: shared state encoding and default widths for the Neander memory interface.
package neander_pkg;
  typedef enum logic [1:0] {IDLE, RD, WR} mem_state_t;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
endpackage

// File: rtl/mem_wait_cnt.sv
// mem_wait_cnt: 4-bit loadable down-counter that stops at zero and flags it.
module mem_wait_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] value,
  input  logic       en,
  output logic       zero
);
  logic [3:0] cnt;
  assign zero = cnt == 4'd0;
  always_ff @(posedge clk)
    if (rst) cnt <= 4'd0;
    else if (load) cnt <= value;
    else if (en && !zero) cnt <= cnt - 4'd1;
endmodule

// File: rtl/mem_if_unit.sv
// mem_if_unit: address/data registers with request/done memory sequencing and read wait states.
// Define MEM_IF_AUTOINC_EN to post-increment addr_q on every completed access.
module mem_if_unit
  import neander_pkg::*;
#(
  parameter int AW   = ADDR_W,
  parameter int DW   = DATA_W,
  parameter int WAIT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_addr,
  input  logic [AW-1:0] addr_in,
  input  logic          inc_addr,
  input  logic          rd_req,
  input  logic          wr_req,
  input  logic [DW-1:0] wr_data,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] addr_q,
  output logic [DW-1:0] data_q,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  mem_state_t state;
  logic idle, zero, fin;
  assign idle      = state == IDLE;
  assign busy      = !idle;
  assign mem_addr  = addr_q;
  assign mem_wdata = data_q;
  assign fin       = (state == RD && zero) || state == WR;
  mem_wait_cnt u_wait (
    .clk  (clk),
    .rst  (rst),
    .load (idle && rd_req && !wr_req),
    .value(4'(WAIT)),
    .en   (state == RD),
    .zero (zero)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state  <= IDLE;
      addr_q <= '0;
      data_q <= '0;
      done   <= 1'b0;
      mem_we <= 1'b0;
    end else begin
      done   <= fin;
      mem_we <= idle && wr_req;
      state  <= idle ? (wr_req ? WR : rd_req ? RD : IDLE) : fin ? IDLE : state;
      if (idle && wr_req) data_q <= wr_data;
      else if (state == RD && zero) data_q <= mem_rdata;
      if (idle) addr_q <= ld_addr ? addr_in : inc_addr ? addr_q + 1'b1 : addr_q;
`ifdef MEM_IF_AUTOINC_EN
      else if (fin) addr_q <= addr_q + 1'b1;
`else
      else addr_q <= addr_q;
`endif
    end
endmodule

// File: tb/tb_mem_if_unit.sv
// tb_mem_if_unit: directed scoreboard bench for mem_if_unit (WAIT=1); honours MEM_IF_AUTOINC_EN.
module tb_mem_if_unit;
`ifdef MEM_IF_AUTOINC_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  logic clk = 1'b0, rst, ld_addr, inc_addr, rd_req, wr_req, mem_we, busy, done;
  logic [7:0] addr_in, wr_data, addr_q, data_q, mem_addr, mem_wdata, mem_rdata;
  logic [7:0] ram [256];
  typedef struct {logic [7:0] data; int lat; int we;} exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;
  assign mem_rdata = ram[mem_addr];

  mem_if_unit #(.AW(8), .DW(8), .WAIT(1)) dut (
    .clk(clk), .rst(rst), .ld_addr(ld_addr), .addr_in(addr_in), .inc_addr(inc_addr),
    .rd_req(rd_req), .wr_req(wr_req), .wr_data(wr_data), .busy(busy), .done(done),
    .addr_q(addr_q), .data_q(data_q), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_addr(input logic [7:0] a, input logic inc);
    ld_addr = 1'b1; inc_addr = inc; addr_in = a;
    @(negedge clk);
    ld_addr = 1'b0; inc_addr = 1'b0;
  endtask

  // Drives one request, optionally holding rd_req/inc_addr while busy, then scores the done pulse.
  task automatic access(input logic wr, input logic rd, input logic hold_rd, input logic hold_inc,
                        input logic [7:0] wd, input logic [7:0] ea, input string tag);
    int n, we_n;
    logic aok, wok;
    exp_t e;
    aok = 1'b1; wok = 1'b1; we_n = 0;
    wr_req = wr; rd_req = rd; wr_data = wd;
    @(negedge clk);
    wr_req = 1'b0; ld_addr = 1'b0; rd_req = hold_rd; inc_addr = hold_inc; n = 1;
    while (!done && n < 20) begin
      if (mem_addr !== ea || addr_q !== ea || busy !== 1'b1) aok = 1'b0;
      if (mem_we) begin
        we_n++;
        if (mem_wdata !== wd) wok = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    rd_req = 1'b0; inc_addr = 1'b0;
    chk({tag, " sb_entry"}, 32'(sb.size() > 0), 1);
    e = sb.pop_front();
    chk({tag, " done"}, done, 1);
    chk({tag, " latency"}, n, e.lat);
    chk({tag, " data_q"}, data_q, e.data);
    chk({tag, " addr_stable"}, aok, 1);
    chk({tag, " we_cycles"}, we_n, e.we);
    if (e.we != 0) chk({tag, " wdata"}, wok, 1);
    @(negedge clk);
    chk({tag, " done_one_cycle"}, done, 0);
    chk({tag, " idle_after"}, busy, 0);
  endtask

  initial begin
    int p;
    logic [7:0] ea;
    rst = 1'b1; ld_addr = 1'b0; inc_addr = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
    addr_in = '0; wr_data = '0;
    for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'h5A;
    ram[8'h2A] = 8'hC3;
    repeat (2) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst addr_q", addr_q, 0);
    chk("rst data_q", data_q, 0);
    chk("rst mem_we", mem_we, 0);
    rst = 1'b0;

    // reset in the middle of a read aborts it silently
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    chk("abort busy_before", busy, 1);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("abort done_in_rst", done, 0);
    end
    rst = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort addr_q", addr_q, 0);
    chk("abort data_q", data_q, 0);
    p = 0;
    repeat (4) begin
      @(negedge clk);
      p += int'(done);
    end
    chk("abort no_done", p, 0);

    // read with one wait state
    load_addr(8'h2A, 1'b0);
    chk("ld addr_q", addr_q, 8'h2A);
    sb.push_back('{8'hC3, 3, 0});
    access(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h2A, "rd2A");

    // single write
    load_addr(8'h10, 1'b0);
    sb.push_back('{8'h5E, 2, 1});
    access(1'b1, 1'b0, 1'b0, 1'b0, 8'h5E, 8'h10, "wr10");

    // simultaneous requests: write wins, held read while busy is dropped
    load_addr(8'h10, 1'b0);
    sb.push_back('{8'h77, 2, 1});
    access(1'b1, 1'b1, 1'b1, 1'b0, 8'h77, 8'h10, "both");
    p = 0;
    repeat (5) begin
      @(negedge clk);
      p += int'(done);
    end
    chk("dropped_rd no_done", p, 0);
    chk("dropped_rd sb_empty", sb.size(), 0);

    // wrap-around and ld/inc priority
    load_addr(8'hFF, 1'b0);
    chk("preload FF", addr_q, 8'hFF);
    inc_addr = 1'b1;
    @(negedge clk);
    inc_addr = 1'b0;
    chk("wrap FF+1", addr_q, 8'h00);
    load_addr(8'h07, 1'b1);
    chk("ld_over_inc", addr_q, 8'h07);

    // address load in the accept cycle moves the access; inc while busy is ignored
    ld_addr = 1'b1; addr_in = 8'h30;
    sb.push_back('{ram[8'h30], 3, 0});
    access(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h30, "rd_ld_same_cycle");
    chk("inc_ignored_busy", addr_q, AUTO ? 8'h31 : 8'h30);

    // three reads from FE: auto-increment walks the address across the wrap
    load_addr(8'hFE, 1'b0);
    for (int i = 0; i < 3; i++) begin
      ea = AUTO ? 8'(8'hFE + i) : 8'hFE;
      sb.push_back('{ram[ea], 3, 0});
      access(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, ea, $sformatf("seq%0d", i));
    end
    chk("seq final addr_q", addr_q, AUTO ? 8'h01 : 8'hFE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
